pc_fetch: RTL and testbench

//  Instruction-fetch front end. Holds the architectural PC, issues word fetches to

---
 rtl/pc_fetch.sv | 117 +++++++++++
 tb/tb_pc_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, in-order word fetch with a 2-slot credit,
// redirect handling that drops stale responses, and a 2-entry (pc, instr) output FIFO.

module pc_fetch_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] rdata
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset; consumers only look at it when count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !(rst || flush)) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [29:0] redirect_npc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [29:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;

  logic [29:0] pc;
  logic [29:0] tag_head;
  logic [1:0]  outstanding, fifo_count, drop_cnt;
  logic        credit_ok, issue, resp_ok, resp_keep, out_pop;
  fetch_pair_t push_pair, head_pair;

  // In-flight plus buffered never exceeds the 2 FIFO slots, so every kept
  // response has somewhere to land.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < 3'd2;
  assign imem_req  = !rst && !redirect && credit_ok;
  assign imem_addr = rst ? '0 : pc;
  assign issue     = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = imem_rvalid && (outstanding != 2'd0);
  assign resp_keep = resp_ok && (drop_cnt == 2'd0) && !redirect;
  assign out_pop   = if_valid && id_ready && !redirect;
  assign push_pair = {tag_head, imem_rdata};

  pc_fetch_fifo2 #(.W(30)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (issue),
    .wdata (pc),
    .pop   (resp_ok),
    .count (outstanding),
    .rdata (tag_head)
  );

  pc_fetch_fifo2 #(.W(62)) u_out_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (resp_keep),
    .wdata (push_pair),
    .pop   (out_pop),
    .count (fifo_count),
    .rdata (head_pair)
  );

  always_ff @(posedge clk) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= redirect_npc;
    else if (issue)    pc <= pc + 30'd1;
  end

  // Everything still in flight after this cycle belongs to the old path.
  always_ff @(posedge clk) begin
    if (rst)                              drop_cnt <= 2'd0;
    else if (redirect)                    drop_cnt <= outstanding - {1'b0, resp_ok};
    else if (resp_ok && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
  end

  assign if_valid = (fifo_count != 2'd0);
  assign if_pc    = if_valid ? head_pair.pc    : '0;
  assign if_instr = if_valid ? head_pair.instr : '0;
endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed scenarios followed by randomized traffic,
// checked against a queue-based model of the fetch front end.

module tb_pc_fetch;
  localparam logic [29:0] RST_PC = 30'h0000_0C00;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_gnt, imem_rvalid, id_ready;
  logic [29:0] redirect_npc, imem_addr, if_pc;
  logic [31:0] imem_rdata, if_instr;
  logic        imem_req, if_valid;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_npc (redirect_npc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .id_ready     (id_ready)
  );

  typedef struct {logic [29:0] pc; bit drop;} infl_t;
  typedef struct {logic [29:0] pc; logic [31:0] instr;} pair_t;

  // Model: requests the memory has accepted (oldest first) and pairs decode should see.
  infl_t       inflight[$];
  pair_t       exp_q[$];
  logic [29:0] issue_log[$];
  logic [29:0] deliv_log[$];
  logic [29:0] m_pc = RST_PC;
  int          n_chk = 0, n_pass = 0, n_issue = 0, rst_cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples just after the falling edge and advances the model to the next rising edge.
  always @(negedge clk) begin
    infl_t t;
    bit    room;
    #2;
    if (rst) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      if (rst_cyc > 0) begin
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
      end
      rst_cyc++;
      m_pc = RST_PC;
      inflight.delete();
      exp_q.delete();
    end else begin
      rst_cyc = 0;
      room = (inflight.size() + exp_q.size()) < 2;
      chk("imem_req", imem_req, !redirect && room);
      if (imem_req) chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", if_valid, exp_q.size() != 0);
      if (if_valid && exp_q.size() != 0) begin
        chk("if_pc", if_pc, exp_q[0].pc);
        chk("if_instr", if_instr, exp_q[0].instr);
        if (id_ready && !redirect) begin
          deliv_log.push_back(if_pc);
          void'(exp_q.pop_front());
        end
      end
      if (imem_rvalid && inflight.size() != 0) begin
        t = inflight.pop_front();
        if (!t.drop && !redirect) exp_q.push_back('{pc: t.pc, instr: imem_rdata});
      end
      if (redirect) begin
        exp_q.delete();
        foreach (inflight[i]) inflight[i].drop = 1'b1;
        m_pc = redirect_npc;
      end else if (imem_req && imem_gnt) begin
        inflight.push_back('{pc: m_pc, drop: 1'b0});
        issue_log.push_back(imem_addr);
        m_pc = m_pc + 30'd1;
        n_issue++;
      end
    end
  end

  // rvm: 0 none, 1 respond whenever pending, 2 random (rare stray when idle), 3 force
  task automatic cyc(bit rs, bit g, int rvm, bit rdy, bit rd, logic [29:0] npc);
    @(negedge clk);
    rst          = rs;
    imem_gnt     = g;
    id_ready     = rdy;
    redirect     = rd && !rs;
    redirect_npc = npc;
    imem_rdata   = $urandom;
    case (rvm)
      1:       imem_rvalid = (inflight.size() != 0);
      2:       imem_rvalid = (inflight.size() != 0) ? ($urandom_range(0, 9) < 6)
                                                   : ($urandom_range(0, 49) == 0);
      3:       imem_rvalid = 1'b1;
      default: imem_rvalid = 1'b0;
    endcase
    if (rs) imem_rvalid = 1'b0;
  endtask

  task automatic drain(int n);
    repeat (n) cyc(0, 0, 1, 1, 0, '0);
  endtask

  initial begin
    int          n0, d0, il0;
    logic [29:0] v0, v1;
    bit          rs, rd, g, rdy;
    logic [29:0] npc;
    rst = 1'b1; redirect = 1'b0; redirect_npc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    repeat (3) cyc(1, 0, 0, 0, 0, '0);

    // Streaming fetch from the reset PC
    repeat (12) cyc(0, 1, 1, 1, 0, '0);
    #3 chk("t1_first_issue", issue_log.size() > 0 ? issue_log[0] : 30'h0, RST_PC);
    drain(6);

    // Decode stalled: credit stops issue at two
    #3 n0 = n_issue;
    repeat (8) cyc(0, 1, 1, 0, 0, '0);
    #3 chk("t2_issue_cnt", n_issue - n0, 2);
    drain(6);

    // Redirect with two outstanding: both dropped, new stream from 0x100
    repeat (2) cyc(0, 1, 0, 1, 0, '0);
    #3 d0 = deliv_log.size();
    cyc(0, 1, 0, 1, 1, 30'h100);
    repeat (8) cyc(0, 1, 1, 1, 0, '0);
    #3 v0 = '1;
    if (deliv_log.size() > d0) v0 = deliv_log[d0];
    chk("t3_first_pc", v0, 30'h100);
    drain(6);

    // Redirect + rvalid + pop in one cycle, target at the top of the address space
    cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 1, 1, 0, 0, '0);
    #3 il0 = issue_log.size();
    cyc(0, 1, 1, 1, 1, 30'h3FFF_FFFF);
    repeat (6) cyc(0, 1, 1, 1, 0, '0);
    #3 chk("t5_issue_cnt_ok", issue_log.size() >= il0 + 2, 1);
    v0 = '0; v1 = '1;
    if (issue_log.size() >= il0 + 2) begin
      v0 = issue_log[il0];
      v1 = issue_log[il0 + 1];
    end
    chk("t5_top_addr", v0, 30'h3FFF_FFFF);
    chk("t5_wrap_addr", v1, 30'h0);
    drain(6);

    // Stray response with nothing outstanding
    cyc(0, 0, 3, 1, 0, '0);
    repeat (3) cyc(0, 1, 1, 1, 0, '0);
    drain(6);

    // Reset with a buffered pair and a request in flight
    repeat (2) cyc(0, 1, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    repeat (2) cyc(1, 0, 0, 0, 0, '0);
    #3 n0 = issue_log.size();
    repeat (4) cyc(0, 1, 1, 1, 0, '0);
    #3 v0 = '1;
    if (issue_log.size() > n0) v0 = issue_log[n0];
    chk("t6_post_rst_addr", v0, RST_PC);
    drain(6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs  = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      g   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       npc = 30'h3FFF_FFFF;
        1:       npc = 30'h3FFF_FFFE;
        default: npc = 30'($urandom);
      endcase
      cyc(rs, g, 2, rdy, rd, npc);
    end
    drain(8);
    #3 chk("end_exp_empty", exp_q.size(), 0);
    chk("end_inflight_empty", inflight.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
